// File: rtl/bsg_manycore_array_reset_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_array_reset_sequencer
//
// Brings up one compute subarray. On a start command it latches the pod and
// offset coordinates and drives the per-column global X/Y seeds into the top
// row of the tile array. It holds every column in reset while the seeds
// settle, then releases the column resets one at a time, in order
// 0..N-1. Spreading the releases out bounds the wake-up current that flows
// when many tiles leave reset together.
//
// Parameters:
//   subarray_num_tiles_x_p  columns driven (>= 1)
//   num_tiles_x_p           pod width in tiles (sets the X subcoord width)
//   num_tiles_y_p           pod height in tiles (sets the Y subcoord width)
//   pod_x/y_cord_width_p    pod coordinate field widths
//   settle_cycles_p         cycles of stable seeds before column 0 (>= 1)
//   stagger_cycles_p        cycles between successive releases (>= 1)
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   start_v_i/start_ready_o start handshake (ready is combinational)
//   pod_x_i, pod_y_i        pod coordinates, sampled on accept
//   x_offset_i, y_offset_i  subcoords of column 0 / top row, sampled on accept
//   abort_i                 back to idle and reassert every column reset
//   reset_o                 per-column tile reset, active-high
//   global_x_o, global_y_o  per-column coordinate seeds
//   done_o                  every column released
// ---------------------------------------------------------------------------
module bsg_manycore_array_reset_sequencer #(
  parameter int subarray_num_tiles_x_p = 4,
  parameter int num_tiles_x_p          = 16,
  parameter int num_tiles_y_p          = 8,
  parameter int pod_x_cord_width_p     = 3,
  parameter int pod_y_cord_width_p     = 4,
  parameter int settle_cycles_p        = 3,
  parameter int stagger_cycles_p       = 2,
  localparam int x_subcord_width_lp    = (num_tiles_x_p <= 1) ? 1 : $clog2(num_tiles_x_p),
  localparam int y_subcord_width_lp    = (num_tiles_y_p <= 1) ? 1 : $clog2(num_tiles_y_p),
  localparam int x_cord_width_p        = pod_x_cord_width_p + x_subcord_width_lp,
  localparam int y_cord_width_p        = pod_y_cord_width_p + y_subcord_width_lp
) (
  input  logic                                                   clk_i,
  input  logic                                                   reset_n_i,
  input  logic                                                   start_v_i,
  output logic                                                   start_ready_o,
  input  logic [pod_x_cord_width_p-1:0]                          pod_x_i,
  input  logic [pod_y_cord_width_p-1:0]                          pod_y_i,
  input  logic [x_subcord_width_lp-1:0]                          x_offset_i,
  input  logic [y_subcord_width_lp-1:0]                          y_offset_i,
  input  logic                                                   abort_i,
  output logic [subarray_num_tiles_x_p-1:0]                      reset_o,
  output logic [subarray_num_tiles_x_p-1:0][x_cord_width_p-1:0]  global_x_o,
  output logic [subarray_num_tiles_x_p-1:0][y_cord_width_p-1:0]  global_y_o,
  output logic                                                   done_o
);

  localparam int max_wait_lp     = (settle_cycles_p > stagger_cycles_p) ? settle_cycles_p
                                                                        : stagger_cycles_p;
  localparam int cnt_width_lp    = ((max_wait_lp + 1) <= 1) ? 1 : $clog2(max_wait_lp + 1);
  localparam int col_width_lp    = (subarray_num_tiles_x_p <= 1) ? 1
                                                                 : $clog2(subarray_num_tiles_x_p);

  localparam logic [cnt_width_lp-1:0] settle_load_lp  = cnt_width_lp'(settle_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] stagger_load_lp = cnt_width_lp'(stagger_cycles_p - 1);
  localparam logic [col_width_lp-1:0] last_col_lp     = col_width_lp'(subarray_num_tiles_x_p - 1);
  localparam bit                      single_col_lp   = (subarray_num_tiles_x_p == 1);

  typedef enum logic [1:0] {
    e_idle,
    e_settle,
    e_release,
    e_done
  } state_e;

  state_e                                                 state_q;
  logic [cnt_width_lp-1:0]                                cnt_q;
  logic [col_width_lp-1:0]                                col_q;
  logic [subarray_num_tiles_x_p-1:0]                      reset_q;
  logic                                                   done_q;
  logic [subarray_num_tiles_x_p-1:0][x_cord_width_p-1:0]  global_x_q;
  logic [subarray_num_tiles_x_p-1:0][y_cord_width_p-1:0]  global_y_q;

  // Seeds captured on accept. The X subcoord wraps inside its own field so a
  // column past the pod edge never carries into the pod X field.
  logic [subarray_num_tiles_x_p-1:0][x_cord_width_p-1:0]  global_x_d;
  logic [subarray_num_tiles_x_p-1:0][y_cord_width_p-1:0]  global_y_d;

  // NOTE: every output of an always_comb is given a value before any
  // conditional or loop touches it, so no latch can be inferred.
  always_comb begin
    global_x_d = '0;
    global_y_d = '0;
    for (int c = 0; c < subarray_num_tiles_x_p; c++) begin
      global_x_d[c] = {pod_x_i, x_offset_i + x_subcord_width_lp'(c)};
      global_y_d[c] = {pod_y_i, y_offset_i};
    end
  end

  // Abort is folded in here so it blocks a start in the same cycle.
  assign start_ready_o = ((state_q == e_idle) || (state_q == e_done)) && !abort_i;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      cnt_q      <= '0;
      col_q      <= '0;
      reset_q    <= '1;
      done_q     <= 1'b0;
      global_x_q <= '0;
      global_y_q <= '0;
    end else if (abort_i) begin
      // Seeds are left alone; only the resets and the sequence restart.
      state_q <= e_idle;
      cnt_q   <= '0;
      col_q   <= '0;
      reset_q <= '1;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        e_idle, e_done: begin
          if (start_v_i) begin
            state_q    <= e_settle;
            cnt_q      <= settle_load_lp;
            col_q      <= '0;
            reset_q    <= '1;
            done_q     <= 1'b0;
            global_x_q <= global_x_d;
            global_y_q <= global_y_d;
          end
        end

        e_settle: begin
          if (cnt_q == '0) begin
            reset_q[0] <= 1'b0;
            col_q      <= col_width_lp'(1);
            cnt_q      <= stagger_load_lp;
            if (single_col_lp) begin
              state_q <= e_done;
              done_q  <= 1'b1;
            end else begin
              state_q <= e_release;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        e_release: begin
          if (cnt_q == '0) begin
            // Compare rather than index so a column count that is not a
            // power of two never addresses a bit past the top of reset_q.
            for (int c = 0; c < subarray_num_tiles_x_p; c++) begin
              if (col_width_lp'(c) == col_q) begin
                reset_q[c] <= 1'b0;
              end
            end
            if (col_q == last_col_lp) begin
              state_q <= e_done;
              done_q  <= 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
              cnt_q <= stagger_load_lp;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= e_idle;
        end
      endcase
    end
  end

  assign reset_o    = reset_q;
  assign done_o     = done_q;
  assign global_x_o = global_x_q;
  assign global_y_o = global_y_q;

endmodule

// File: tb/tb_bsg_manycore_array_reset_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for bsg_manycore_array_reset_sequencer.
//
// The driver issues one command per cycle and, for each accepted start or
// abort, pushes the output snapshots the subarray must show at the affected
// edges into a scoreboard queue. Release edges come straight from the timing
// rule T + settle + c*stagger. A monitor on the falling edge pops an entry
// when its edge arrives and compares it; any output change with no entry
// due is reported. A second instance covers one column with settle=1.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_array_reset_sequencer;

  localparam int N  = 4;
  localparam int ST = 3;
  localparam int SG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              start_v, abort, start_ready, done;
  logic [2:0]        pod_x;
  logic [3:0]        pod_y;
  logic [3:0]        x_off;
  logic [2:0]        y_off;
  logic [N-1:0]      rst_o;
  logic [N-1:0][6:0] gx, gy;

  bsg_manycore_array_reset_sequencer #(
    .subarray_num_tiles_x_p(N), .num_tiles_x_p(16), .num_tiles_y_p(8),
    .pod_x_cord_width_p(3), .pod_y_cord_width_p(4),
    .settle_cycles_p(ST), .stagger_cycles_p(SG)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_v_i(start_v), .start_ready_o(start_ready),
    .pod_x_i(pod_x), .pod_y_i(pod_y), .x_offset_i(x_off), .y_offset_i(y_off),
    .abort_i(abort), .reset_o(rst_o), .global_x_o(gx), .global_y_o(gy), .done_o(done)
  );

  // Single column, settle=1.
  logic              s2_start, s2_ready, s2_done, s2_rst;
  logic [2:0]        s2_px;
  logic [3:0]        s2_py;
  logic [3:0]        s2_xo;
  logic [2:0]        s2_yo;
  logic [0:0][6:0]   s2_gx, s2_gy;

  bsg_manycore_array_reset_sequencer #(
    .subarray_num_tiles_x_p(1), .num_tiles_x_p(16), .num_tiles_y_p(8),
    .pod_x_cord_width_p(3), .pod_y_cord_width_p(4),
    .settle_cycles_p(1), .stagger_cycles_p(1)
  ) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .start_v_i(s2_start), .start_ready_o(s2_ready),
    .pod_x_i(s2_px), .pod_y_i(s2_py), .x_offset_i(s2_xo), .y_offset_i(s2_yo),
    .abort_i(1'b0), .reset_o(s2_rst), .global_x_o(s2_gx), .global_y_o(s2_gy), .done_o(s2_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           cyc;
    logic [60:0]  outs;   // {reset, done, global_x, global_y}
  } ev_t;

  ev_t sb_q[$];

  // Reference model state.
  logic [N-1:0][6:0] m_gx = '0, m_gy = '0;
  bit                m_idle = 1'b1;
  int                m_done_edge = 0;

  function automatic logic [60:0] snap();
    return {rst_o, done, gx, gy};
  endfunction

  function automatic void push_ev(input int e, input logic [N-1:0] r, input logic d);
    ev_t ev;
    ev.cyc  = e;
    ev.outs = {r, d, m_gx, m_gy};
    sb_q.push_back(ev);
  endfunction

  function automatic void drop_from(input int e);
    while (sb_q.size() > 0 && sb_q[$].cyc >= e) void'(sb_q.pop_back());
  endfunction

  function automatic void model_accept(input int e, input int px, input int py,
                                       input int xo, input int yo);
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) begin
      m_gx[c] = 7'(px * 16 + (xo + c) % 16);
      m_gy[c] = 7'(py * 8 + yo);
    end
    push_ev(e, '1, 1'b0);
    for (int c = 0; c < N; c++) begin
      r = 4'hf << (c + 1);
      push_ev(e + ST + c * SG, r, c == N - 1);
    end
    m_idle      = 1'b0;
    m_done_edge = e + ST + (N - 1) * SG;
  endfunction

  function automatic void model_abort(input int e);
    drop_from(e);
    push_ev(e, '1, 1'b0);
    m_idle = 1'b1;
  endfunction

  // One command per cycle; the next rising edge is where the DUT acts on it.
  task automatic step(input logic sv, input logic ab, input logic [2:0] px,
                      input logic [3:0] py, input logic [3:0] xo, input logic [2:0] yo);
    bit ready_m;
    @(negedge clk);
    #1;
    start_v = sv; abort = ab; pod_x = px; pod_y = py; x_off = xo; y_off = yo;
    #1;
    ready_m = m_idle || (cyc >= m_done_edge);
    check("start_ready", start_ready, ready_m && !ab);
    if (ab)                  model_abort(cyc + 1);
    else if (sv && ready_m)  model_accept(cyc + 1, px, py, xo, yo);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 3'd0);
  endtask

  // Monitor.
  bit          mon_en = 1'b0;
  logic [60:0] prev;
  logic [60:0] cur;
  always @(negedge clk) begin
    if (mon_en) begin
      cur = snap();
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check("event_missed_at_cycle", 64'(sb_q[0].cyc), 64'(cyc));
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        check("outputs", 64'(cur), 64'(sb_q[0].outs));
        void'(sb_q.pop_front());
      end else if (cur !== prev) begin
        check("unexpected_change", 64'(cur), 64'(prev));
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start_v = 0; abort = 0; pod_x = 0; pod_y = 0; x_off = 0; y_off = 0;
    s2_start = 0; s2_px = 3'd5; s2_py = 4'd3; s2_xo = 4'd9; s2_yo = 3'd6;
    #12;
    // Reset values.
    check("rst_reset_o", rst_o, 4'hf);
    check("rst_gx", gx, '0);
    check("rst_gy", gy, '0);
    check("rst_done", done, 1'b0);
    check("rst_ready", start_ready, 1'b1);
    check("rst_n1_reset_o", s2_rst, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    prev    = snap();
    mon_en  = 1'b1;

    // Nominal start.
    step(1'b1, 1'b0, 3'd1, 4'd2, 4'd4, 3'd1);
    idle(1);
    check("nominal_gx", gx, {7'h17, 7'h16, 7'h15, 7'h14});
    check("nominal_gy", gy, {4{7'h11}});
    idle(10);

    // X subcoord wrap.
    step(1'b1, 1'b0, 3'd1, 4'd2, 4'd14, 3'd1);
    idle(1);
    check("wrap_gx", gx, {7'h11, 7'h10, 7'h1f, 7'h1e});
    idle(10);

    // Abort after the second release, then full restart.
    step(1'b1, 1'b0, 3'd3, 4'd5, 4'd7, 3'd2);
    idle(5);
    step(1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 3'd0);
    idle(2);
    step(1'b1, 1'b0, 3'd3, 4'd5, 4'd7, 3'd2);
    idle(11);

    // Restart from DONE with a new pod X.
    step(1'b1, 1'b0, 3'd2, 4'd2, 4'd4, 3'd1);
    idle(1);
    check("restart_gx0", gx[0], 7'h24);
    check("restart_reset_o", rst_o, 4'hf);
    idle(10);

    // Start and abort together: abort wins.
    step(1'b1, 1'b1, 3'd6, 4'd6, 4'd6, 3'd6);
    idle(3);

    // Randomized commands.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 3) == 0, ($urandom % 25) == 0,
           3'($urandom), 4'($urandom), 4'($urandom), 3'($urandom));
    end
    idle(12);

    // Asynchronous reset in the middle of the release sequence.
    step(1'b1, 1'b0, 3'd4, 4'd9, 4'd13, 3'd3);
    idle(6);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset_o", rst_o, 4'hf);
    check("async_gx", gx, '0);
    check("async_gy", gy, '0);
    check("async_done", done, 1'b0);
    check("async_ready", start_ready, 1'b1);
    drop_from(cyc);
    m_gx = '0;
    m_gy = '0;
    push_ev(cyc, '1, 1'b0);
    m_idle = 1'b1;
    #1;
    reset_n = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 3'd7, 4'd15, 4'd15, 3'd7);
    idle(25);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    // Single column, settle=1: release and done one edge after accept.
    @(negedge clk);
    s2_start = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0;
    check("n1_accept_reset", s2_rst, 1'b1);
    check("n1_accept_done", s2_done, 1'b0);
    check("n1_accept_ready", s2_ready, 1'b0);
    check("n1_gx", s2_gx, 7'h59);
    check("n1_gy", s2_gy, 7'h1e);
    @(posedge clk);
    #1;
    check("n1_release_reset", s2_rst, 1'b0);
    check("n1_release_done", s2_done, 1'b1);
    check("n1_release_ready", s2_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_manycore_array_reset_sequencer.md
# bsg_manycore_array_reset_sequencer

Sequences bring-up of one compute subarray: latches pod and offset coordinates, drives the per-column global X/Y coordinate seeds and reset lines into the top row of the tile array, and releases column resets in a staggered order to bound simultaneous wake-up current. It sits directly north of the subarray, driving its per-column `reset_i`, `global_x_i` and `global_y_i` inputs. It accepts start and abort commands from the pod-level controller.

## Interface
- `subarray_num_tiles_x_p`, no default: number of columns driven; must be ≥1.
- `num_tiles_x_p`, no default: pod width in tiles; `x_subcord_width_lp = BSG_SAFE_CLOG2(num_tiles_x_p)`.
- `num_tiles_y_p`, no default: pod height in tiles; `y_subcord_width_lp = BSG_SAFE_CLOG2(num_tiles_y_p)`.
- `pod_x_cord_width_p`, `pod_y_cord_width_p`, no default: pod coordinate widths.
- `x_cord_width_p` = `pod_x_cord_width_p + x_subcord_width_lp`; `y_cord_width_p` = `pod_y_cord_width_p + y_subcord_width_lp`.
- `settle_cycles_p`, default 3: cycles of coordinate hold before the first release; must be ≥1.
- `stagger_cycles_p`, default 2: cycles between successive column releases; must be ≥1.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous active-low reset.
- `start_v_i`  in  1  start request.
- `start_ready_o`  out  1  start accepted when `start_v_i & start_ready_o`.
- `pod_x_i`  in  `pod_x_cord_width_p`  pod X, sampled on accept.
- `pod_y_i`  in  `pod_y_cord_width_p`  pod Y, sampled on accept.
- `x_offset_i`  in  `x_subcord_width_lp`  X subcoord of column 0, sampled on accept.
- `y_offset_i`  in  `y_subcord_width_lp`  Y subcoord of the top row, sampled on accept.
- `abort_i`  in  1  return to IDLE and reassert all resets.
- `reset_o`  out  `subarray_num_tiles_x_p`  per-column tile reset, active-high.
- `global_x_o`  out  `subarray_num_tiles_x_p` x `x_cord_width_p`  per-column X seed.
- `global_y_o`  out  `subarray_num_tiles_x_p` x `y_cord_width_p`  per-column Y seed.
- `done_o`  out  1  all columns released.

## Operation
- States: IDLE, SETTLE, RELEASE, DONE. A single down-counter `cnt_r` is sized `BSG_SAFE_CLOG2(max(settle,stagger)+1)`. A column index `col_r` is sized `BSG_SAFE_CLOG2(subarray_num_tiles_x_p)`.
- `start_ready_o` = (state==IDLE | state==DONE) & ~`abort_i`. It is combinational.
- **Accept:** at the edge where `start_v_i & start_ready_o`:
  - latch all coordinates;
  - set every `reset_o` bit to 1;
  - clear `done_o`;
  - set `cnt_r` = `settle_cycles_p`-1;
  - go to SETTLE.
  - Accepting from DONE restarts the sequence in the same way.
- **Coordinates:**
  - `global_x_o[c]` = {pod_x, (x_offset + c) mod 2^x_subcord_width_lp}. Wrap-around is required, with no carry into the pod field.
  - `global_y_o[c]` = {pod_y, y_offset} for every column.
  - Outputs are registered and change only on accept.
- **SETTLE:** decrement `cnt_r` each cycle. At the edge where `cnt_r`==0:
  - clear `reset_o[0]`;
  - set `col_r`=1 and `cnt_r`=`stagger_cycles_p`-1;
  - go to RELEASE, or go to DONE with `done_o`=1 if `subarray_num_tiles_x_p`==1.
- **RELEASE:** decrement `cnt_r`. At `cnt_r`==0:
  - clear `reset_o[col_r]`;
  - if `col_r` is the last column, go to DONE with `done_o`=1;
  - otherwise increment `col_r` and reload `cnt_r`=`stagger_cycles_p`-1.
- Columns are released strictly in order 0 to N-1. Once cleared, a `reset_o` bit stays 0 until accept, abort or reset.
- **DONE:** hold all outputs.
- **`abort_i`** (any state, highest priority, wins over a simultaneous start):
  - next edge sets all `reset_o` to 1 and `done_o`=0;
  - go to IDLE;
  - coordinate outputs keep their last values.
- **`reset_n_i` low** (asynchronous, any time, including mid-RELEASE):
  - state = IDLE;
  - `reset_o` = all 1s;
  - `global_x_o` = `global_y_o` = 0;
  - `done_o`=0, `cnt_r`=0, `col_r`=0;
  - `start_ready_o` reads 1 while `abort_i`=0.

## Timing
- Take accept at edge T. Column c's `reset_o` falls at edge T + `settle_cycles_p` + c·`stagger_cycles_p`.
- `done_o` rises at the same edge as the last column's release.
- Coordinates are valid from edge T. This gives at least `settle_cycles_p` cycles of stable coordinates before any release.
- `start_ready_o` is low from edge T until DONE.
- There is no combinational path from inputs to `reset_o`, `global_*_o` or `done_o`.

## Test plan
Common configuration for tests 1-4: N=4, `num_tiles_x_p`=16, `num_tiles_y_p`=8, pod widths 3/4, settle=3, stagger=2.

1. Reset values: hold `reset_n_i`=0 -> `reset_o`=4'b1111, all coordinates 0, `done_o`=0, `start_ready_o`=1.
2. Nominal start: start at edge 0 with pod_x=1, pod_y=2, x_offset=4, y_offset=1.
   - `global_x_o` = 0x14, 0x15, 0x16, 0x17 and every `global_y_o` = 0x11 from edge 0.
   - `reset_o` bits 0/1/2/3 fall at edges 3/5/7/9.
   - `done_o`=1 at edge 9.
3. Wrap: x_offset=14 -> column subcoords 14, 15, 0, 1, so `global_x_o` = 0x1E, 0x1F, 0x10, 0x11.
4. Abort after the edge-5 release -> next edge `reset_o`=1111, state IDLE, `done_o`=0. A new start restarts the full 3/5/7/9 schedule.
5. Restart from DONE and simultaneous start+abort:
   - Start accepted in DONE with new pod_x=2 -> all resets reassert at accept, `global_x_o[0]`=0x24, and the schedule repeats.
   - start+abort in the same cycle -> no accept, state IDLE.
6. Edge parameters: N=1 with settle=1 -> `reset_o[0]` falls and `done_o` rises at edge T+1. Also, `reset_n_i` pulsed low mid-RELEASE -> outputs return asynchronously to their reset values.
